async_up_ct: RTL

ASYNC_UP_CT -- requirements
Module: async_up_ct

---
 rtl/ct_pkg.sv | 14 +
 rtl/async_up_ct.sv | 108 ++++++++++
 2 files changed

// File: rtl/ct_pkg.sv
// Shared definitions for the up-counter: FSM state encoding and the
// sat_mode constants.
package ct_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        SAT  = 2'd2
    } ct_state_t;

    localparam logic MODE_WRAP = 1'b0;
    localparam logic MODE_SAT  = 1'b1;

endpackage

// File: rtl/async_up_ct.sv
// Loadable up-counter with wrap or saturate at MAX.
// It also has a registered wrap pulse and a sticky overflow flag.
module async_up_ct
    import ct_pkg::*;
#(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             areset_n,
    input  logic             load,
    input  logic [WIDTH-1:0] data,
    input  logic             en,
    input  logic             sat_mode,
    input  logic             ovf_clr,
    output logic [WIDTH-1:0] q,
    output logic             wrap,
    output logic             ovf,
    output logic             busy
);

    localparam logic [WIDTH-1:0] MAX = {WIDTH{1'b1}};

    ct_state_t        state_q, state_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             wrap_q, wrap_d;
    logic             ovf_q, ovf_d;
    logic             busy_q, busy_d;
    logic             ovf_set;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wrap_d  = 1'b0;
        ovf_set = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (load) begin
                    state_d = RUN;
                    cnt_d   = data;
                end else if (en) begin
                    state_d = RUN;
                    cnt_d   = cnt_q + WIDTH'(1);
                end
            end
            RUN: begin
                if (load) begin
                    cnt_d = data;
                end else if (en) begin
                    if (cnt_q != MAX) begin
                        cnt_d = cnt_q + WIDTH'(1);
                    end else if (sat_mode == MODE_SAT) begin
                        ovf_set = 1'b1;
                        state_d = SAT;
                    end else begin
                        cnt_d   = '0;
                        wrap_d  = 1'b1;
                        ovf_set = 1'b1;
                    end
                end
            end
            SAT: begin
                // Pinned at MAX until a load reopens counting.
                if (load) begin
                    state_d = RUN;
                    cnt_d   = data;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        // A new overflow wins over a coincident clear.
        if (ovf_set) begin
            ovf_d = 1'b1;
        end else if (ovf_clr) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end

        busy_d = (state_d == RUN);
    end

    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            wrap_q  <= 1'b0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wrap_q  <= wrap_d;
            ovf_q   <= ovf_d;
            busy_q  <= busy_d;
        end
    end

    assign q    = cnt_q;
    assign wrap = wrap_q;
    assign ovf  = ovf_q;
    assign busy = busy_q;

endmodule
